// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller between the LC-3 MAR/MDR registers and the MDR input mux.
// Runs a fixed wait-state SRAM access, or a single-cycle access to the memory-mapped
// switch/hex port at IO_ADDR, and signals completion with a one-cycle MEM_R pulse.
module mem_io_ctrl #(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  output logic [15:0] MDR_In,
  output logic        MEM_R,
  input  logic [15:0] SW,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_OE,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_STATES);

  state_e     r_state;
  logic [3:0] r_cnt;
  logic       r_we;

  // Request sequencing; every output is a register so the SRAM pins see clean strobes.
  // SRAM_ADDR and SRAM_DQ_out double as the latched address and write data, so they
  // cannot move while an access is in flight.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      MDR_In      <= 16'h0000;
      MEM_R       <= 1'b0;
      HEX_Data    <= 16'h0000;
      SRAM_ADDR   <= 20'h00000;
      SRAM_DQ_out <= 16'h0000;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
    end else begin
      MEM_R <= 1'b0;
      case (r_state)
        StIdle: begin
          if (MEM_REQ) begin
            r_we <= MEM_WE;
            if (MAR == IO_ADDR) begin
              // IO port completes immediately; the SRAM is never strobed.
              if (MEM_WE) HEX_Data <= MDR;
              else        MDR_In   <= SW;
              MEM_R   <= 1'b1;
              r_state <= StDone;
            end else begin
              SRAM_ADDR   <= {4'b0000, MAR};
              SRAM_DQ_out <= MDR;
              r_cnt       <= WaitInit;
              SRAM_CE_N   <= 1'b0;
              SRAM_OE_N   <= MEM_WE;
              SRAM_WE_N   <= ~MEM_WE;
              SRAM_DQ_OE  <= MEM_WE;
              r_state     <= StAccess;
            end
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            if (!r_we) MDR_In <= SRAM_DQ_in;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            MEM_R      <= 1'b1;
            r_state    <= StDone;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: the driver pushes the expected outcome of each
// request, a negedge monitor checks SRAM pins every cycle and pops on each MEM_R.
module tb_mem_io_ctrl;

  localparam int unsigned W = 2;

  logic        Clk = 1'b0;
  logic        Reset_ah;
  logic [15:0] MAR, MDR, SW, SRAM_DQ_in;
  logic        MEM_REQ, MEM_WE;
  logic [15:0] MDR_In, HEX_Data, SRAM_DQ_out;
  logic        MEM_R, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic [19:0] SRAM_ADDR;

  mem_io_ctrl #(.WAIT_STATES(W), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset_ah(Reset_ah), .MAR(MAR), .MDR(MDR), .MEM_REQ(MEM_REQ),
    .MEM_WE(MEM_WE), .MDR_In(MDR_In), .MEM_R(MEM_R), .SW(SW), .HEX_Data(HEX_Data),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          io;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_mdr;
    logic [15:0] exp_hex;
    int          raise;
  } txn_t;

  txn_t sbq[$];
  int   checks = 0;
  int   passed = 0;
  int   strobe_cnt = 0;

  // Reference model: architectural memory plus the two visible registers.
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_mdr = 16'h0000;
  logic [15:0] ref_hex = 16'h0000;
  // Environment SRAM, written only from the DUT pins.
  logic [15:0] sram_mem [logic [15:0]];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Build the expected outcome of one request and advance the reference model.
  task automatic model(input bit io, input bit we, input logic [15:0] addr,
                       input logic [15:0] data, input logic [15:0] sw, output txn_t t);
    t.io = io; t.we = we; t.addr = addr; t.data = data;
    if (io) begin
      if (we) ref_hex = data;
      else    ref_mdr = sw;
    end else if (we) begin
      ref_mem[addr] = data;
    end else begin
      ref_mdr = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
    end
    t.exp_mdr = ref_mdr;
    t.exp_hex = ref_hex;
    t.raise   = 0;
  endtask

  // Monitor: per-cycle SRAM pin checks, environment SRAM, completion scoreboard.
  always @(negedge Clk) begin
    txn_t f;
    if (!SRAM_CE_N) begin
      strobe_cnt++;
      if (sbq.size() == 0) begin
        chk("ce_n_without_request", 32'(SRAM_CE_N), 32'd1);
      end else begin
        f = sbq[0];
        if (f.io) begin
          chk("io_no_sram_strobe", 32'(SRAM_CE_N), 32'd1);
        end else begin
          chk("sram_addr", 32'(SRAM_ADDR), {16'h0, f.addr});
          chk("sram_oe_n", 32'(SRAM_OE_N), 32'(f.we));
          chk("sram_we_n", 32'(SRAM_WE_N), 32'(!f.we));
          chk("sram_dq_oe", 32'(SRAM_DQ_OE), 32'(f.we));
          if (f.we) chk("sram_dq_out", 32'(SRAM_DQ_out), {16'h0, f.data});
        end
      end
      if (!SRAM_WE_N) sram_mem[SRAM_ADDR[15:0]] = SRAM_DQ_out;
    end else begin
      chk("idle_oe_n", 32'(SRAM_OE_N), 32'd1);
      chk("idle_we_n", 32'(SRAM_WE_N), 32'd1);
      chk("idle_dq_oe", 32'(SRAM_DQ_OE), 32'd0);
    end
    if (!SRAM_CE_N && !SRAM_OE_N)
      SRAM_DQ_in = sram_mem.exists(SRAM_ADDR[15:0]) ? sram_mem[SRAM_ADDR[15:0]]
                                                     : dflt(SRAM_ADDR[15:0]);
    else
      SRAM_DQ_in = 16'($urandom);
    if (MEM_R === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("mem_r_unexpected", 32'(MEM_R), 32'd0);
      end else begin
        f = sbq.pop_front();
        chk("latency", 32'(cyc - f.raise), f.io ? 32'd1 : 32'(W + 2));
        chk("mdr_in", 32'(MDR_In), {16'h0, f.exp_mdr});
        chk("hex_data", 32'(HEX_Data), {16'h0, f.exp_hex});
        chk("strobe_cycles", 32'(strobe_cnt), f.io ? 32'd0 : 32'(W + 1));
      end
      strobe_cnt = 0;
    end
  end

  // One request held until MEM_R; MAR/MDR/MEM_WE/SW are scrambled once sampled.
  task automatic do_txn(input bit io, input bit we, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] sw);
    txn_t t;
    bit   got = 0;
    @(negedge Clk);
    MAR = addr; MDR = data; MEM_WE = we; SW = sw; MEM_REQ = 1'b1;
    model(io, we, addr, data, sw, t);
    t.raise = cyc;
    sbq.push_back(t);
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (MEM_R === 1'b1) begin
        got = 1;
        break;
      end
      MAR = 16'($urandom); MDR = 16'($urandom); MEM_WE = 1'($urandom); SW = 16'($urandom);
    end
    MEM_REQ = 1'b0;
    if (!got) begin
      chk("mem_r_timeout", 32'(MEM_R), 32'd1);
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    txn_t t1, t2;
    int   seen;
    Reset_ah = 1'b1; MEM_REQ = 1'b0; MEM_WE = 1'b0;
    MAR = 16'h0000; MDR = 16'h0000; SW = 16'h0000;

    // Reset values after two reset cycles.
    repeat (2) @(negedge Clk);
    chk("rst_mdr_in", 32'(MDR_In), 32'd0);
    chk("rst_hex", 32'(HEX_Data), 32'd0);
    chk("rst_mem_r", 32'(MEM_R), 32'd0);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_dq_out", 32'(SRAM_DQ_out), 32'd0);
    chk("rst_ce_n", 32'(SRAM_CE_N), 32'd1);
    Reset_ah = 1'b0;

    // Reset in the middle of an SRAM read: no completion, MDR_In stays 0.
    ref_mem[16'h3000] = 16'hABCD;
    sram_mem[16'h3000] = 16'hABCD;
    @(negedge Clk);
    MAR = 16'h3000; MEM_WE = 1'b0; MEM_REQ = 1'b1;
    t1.io = 0; t1.we = 0; t1.addr = 16'h3000; t1.data = 16'h0;
    t1.exp_mdr = 16'h0; t1.exp_hex = 16'h0; t1.raise = cyc;
    sbq.push_back(t1);
    repeat (2) @(negedge Clk);
    Reset_ah = 1'b1; MEM_REQ = 1'b0;
    @(negedge Clk);
    sbq.delete();
    strobe_cnt = 0;
    chk("abort_ce_n", 32'(SRAM_CE_N), 32'd1);
    chk("abort_oe_n", 32'(SRAM_OE_N), 32'd1);
    chk("abort_mem_r", 32'(MEM_R), 32'd0);
    chk("abort_mdr_in", 32'(MDR_In), 32'd0);
    Reset_ah = 1'b0;
    repeat (3) @(negedge Clk);
    chk("abort_no_late_mem_r", 32'(MEM_R), 32'd0);

    // Directed accesses.
    do_txn(0, 0, 16'h3000, 16'h1111, 16'h0000);
    do_txn(0, 1, 16'h3001, 16'h5A5A, 16'h0000);
    do_txn(1, 0, 16'hFFFF, 16'h7777, 16'h1234);
    do_txn(1, 1, 16'hFFFF, 16'h00C3, 16'h9999);
    do_txn(0, 0, 16'h3001, 16'h0000, 16'h0000);

    // MEM_REQ held high across two accesses: write then read-back of the same word.
    @(negedge Clk);
    MAR = 16'h3005; MDR = 16'hC0DE; MEM_WE = 1'b1; MEM_REQ = 1'b1;
    model(0, 1, 16'h3005, 16'hC0DE, 16'h0, t1);
    t1.raise = cyc;
    model(0, 0, 16'h3005, 16'h0, 16'h0, t2);
    t2.raise = cyc + W + 3;
    sbq.push_back(t1);
    sbq.push_back(t2);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (MEM_R === 1'b1) seen++;
      if (seen == 2) break;
      if (i == 0) begin
        MEM_WE = 1'b0; MDR = 16'($urandom);
      end
    end
    MEM_REQ = 1'b0;
    chk("busy_mem_r_count", 32'(seen), 32'd2);
    repeat (3) @(negedge Clk);
    if (sbq.size() != 0) begin
      chk("busy_pending", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end

    // Randomized traffic over a small address window so reads hit earlier writes.
    for (int n = 0; n < 60; n++) begin
      bit io;
      io = ($urandom_range(0, 3) == 0);
      do_txn(io, 1'($urandom), io ? 16'hFFFF : 16'(16'h3000 + $urandom_range(0, 7)),
             16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    repeat (4) @(negedge Clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory/IO access controller sitting directly downstream of the LC-3 datapath's MAR/MDR registers and upstream of its MDR input mux. It accepts a read or write request from the control FSM, runs a fixed-wait-state access to the external SRAM, or to a memory-mapped switch/hex-display port at the IO address, and returns read data on MDR_In with a one-cycle ready pulse.

## Interface
- WAIT_STATES, 2, extra SRAM cycles per access beyond the first; legal range 0..15
- IO_ADDR, 16'hFFFF, address decoded as the memory-mapped IO port
- Clk  in  1  system clock, all state on rising edge
- Reset_ah  in  1  reset, synchronous, active-high
- MAR  in  16  access address from the datapath
- MDR  in  16  write data from the datapath
- MEM_REQ  in  1  access request, level, from the control FSM
- MEM_WE  in  1  1 = write, 0 = read; sampled with MEM_REQ
- MDR_In  out  16  read data to the datapath MDR mux (registered)
- MEM_R  out  1  completion pulse, one cycle
- SW  in  16  switch inputs, returned on an IO-address read
- HEX_Data  out  16  display register, loaded on an IO-address write
- SRAM_ADDR  out  20  SRAM address, {4'b0, latched MAR}
- SRAM_DQ_out  out  16  SRAM write data
- SRAM_DQ_in  in  16  SRAM read data
- SRAM_DQ_OE  out  1  1 = drive SRAM_DQ_out onto the pad
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low SRAM strobes

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE:
  - When MEM_REQ=1 is sampled, latch MAR, MDR and MEM_WE into internal address, data and we registers.
  - If MAR==IO_ADDR, go to DONE.
  - Otherwise load the wait counter with WAIT_STATES and go to ACCESS.
- IO read: MDR_In <= SW, captured on the IDLE->DONE edge.
- IO write: HEX_Data <= MDR on the same edge. MDR_In is unchanged.
- ACCESS: strobes are registered and asserted for every ACCESS cycle.
  - SRAM_CE_N=0.
  - Read: SRAM_OE_N=0, SRAM_WE_N=1, SRAM_DQ_OE=0.
  - Write: SRAM_OE_N=1, SRAM_WE_N=0, SRAM_DQ_OE=1, SRAM_DQ_out = latched data.
  - SRAM_ADDR and SRAM_DQ_out stay constant through the whole ACCESS phase.
  - Counter decrements each cycle. On the cycle it reads 0, go to DONE.
  - For reads, capture SRAM_DQ_in into MDR_In on that same edge.
- DONE: MEM_R=1 for exactly one cycle, all strobes deasserted, then IDLE.
- MEM_REQ and MEM_WE are ignored outside IDLE. MAR/MDR changes during an access have no effect.
- The control FSM drops MEM_REQ in the cycle it sees MEM_R. MEM_REQ still high in IDLE is treated as a new request.
- MDR_In holds its value from a read completion until the next read completion.
- Address 16'hFFFF never reaches the SRAM: the strobes stay inactive for IO accesses.

## Timing
- Reset values:
  - State IDLE.
  - MDR_In=0, HEX_Data=0, MEM_R=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_OE=0.
  - SRAM_CE_N=1, SRAM_OE_N=1, SRAM_WE_N=1.
- Reset mid-access: abort at the next edge. Strobes go inactive, no MEM_R, no MDR_In or HEX_Data update.
- Request sampled at edge t:
  - SRAM access: ACCESS occupies cycles t+1..t+1+WAIT_STATES. MEM_R is high in cycle t+2+WAIT_STATES, and MDR_In is valid in that same cycle.
  - IO access: MEM_R is high in cycle t+1, with MDR_In or HEX_Data updated in that cycle.
- Minimum request-to-request spacing: WAIT_STATES+3 cycles for SRAM accesses, 2 cycles for IO accesses.
- WAIT_STATES=0: a single ACCESS cycle.

## Test plan
- Reset: assert Reset_ah 2 cycles -> all outputs at their listed reset values; MEM_R never pulses.
- SRAM read, WAIT_STATES=2, MAR=x3000, SRAM_DQ_in=xABCD -> SRAM_ADDR=x03000; CE_N/OE_N low for 3 cycles; MEM_R high 4 cycles after the request edge; MDR_In=xABCD.
- SRAM write, MAR=x3001, MDR=x5A5A -> WE_N low and DQ_OE high for 3 cycles; SRAM_DQ_out=x5A5A stable while MDR is changed mid-access; MEM_R pulses once; MDR_In unchanged.
- IO read and write:
  - Read at xFFFF with SW=x1234 -> MEM_R next cycle, MDR_In=x1234, no SRAM strobe activity.
  - Write at xFFFF with MDR=x00C3 -> HEX_Data=x00C3.
- Busy/back-to-back: hold MEM_REQ high through an SRAM access -> requests in ACCESS/DONE are ignored; a second access starts from IDLE only; exactly one MEM_R per accepted request.
- Reset during ACCESS (second wait cycle) -> strobes inactive next cycle; no MEM_R; MDR_In keeps its prior value of 0.
